key_event_decoder: RTL and testbench

- Sits between the SoC keycode PIO exports (keycode0, keycode1) and the frame-driven consumers (character, back_controller).
- Samples the two USB HID keycodes once per video frame and decodes them into game actions.
- Produces held levels, single-cycle press/release pulses, a resolved horizontal direction, a saturating hold counter and a buffered jump request with handshake.
- Consumers stop doing raw keycode compares and edge detection themselves.

---
 rtl/key_pkg.sv | 30 +++
 rtl/frame_tick_gen.sv | 32 +++
 rtl/key_event_decoder.sv | 152 +++++++++++++++
 tb/tb_key_event_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the keyboard action decoder and its consumers.
package key_pkg;

  localparam int A_LEFT  = 0;
  localparam int A_RIGHT = 1;
  localparam int A_JUMP  = 2;
  localparam int A_DOWN  = 3;

  typedef logic [3:0] action_vec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_REL = 2'd2
  } jump_state_t;

  // Direction is a 2-bit two's complement step: +1 right, -1 left.
  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  function automatic logic [1:0] resolve_dir(input action_vec_t a);
    logic [1:0] d;
    d = DIR_NONE;
    if (a[A_LEFT] && !a[A_RIGHT]) d = DIR_LEFT;
    if (a[A_RIGHT] && !a[A_LEFT]) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the raw active-low vertical sync into a one-cycle pulse at the end of
// each sync pulse, after a two-flop synchroniser.
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vs,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;
  logic r_tick;

  // Synchroniser resets high (sync idle level) so leaving reset never fakes an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync2_d <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_sync1   <= i_vs;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_tick    <= r_sync2 & ~r_sync2_d;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/key_event_decoder.sv
// Samples the two HID keycodes once per frame and publishes held/pressed/released
// action vectors, a resolved direction, a hold counter and a buffered jump request.
module key_event_decoder
  import key_pkg::*;
#(
  parameter logic [7:0] KC_LEFT     = 8'h04,
  parameter logic [7:0] KC_RIGHT    = 8'h07,
  parameter logic [7:0] KC_JUMP     = 8'h1A,
  parameter logic [7:0] KC_JUMP_ALT = 8'h2C,
  parameter logic [7:0] KC_DOWN     = 8'h16,
  parameter int         JUMP_BUF    = 6,
  parameter int         HOLD_MAX    = 63
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       frame_vs,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       jump_ack,
  output logic       frame_tick,
  output logic [3:0] held,
  output logic [3:0] pressed,
  output logic [3:0] released,
  output logic [1:0] dir,
  output logic [5:0] move_hold,
  output logic       jump_req,
  output logic [1:0] dbg_jump_state
);

  localparam logic [3:0] BUF_LOAD = 4'(JUMP_BUF);
  localparam logic [5:0] HOLD_SAT = 6'(HOLD_MAX);

  // Handshake: jump_req stays high while a jump is pending; a one-cycle jump_ack
  // while pending consumes it and jump_req drops on the following cycle.

  logic        w_tick;
  action_vec_t w_dec;
  logic [1:0]  w_dir;
  logic [5:0]  w_hold_next;

  action_vec_t r_held;
  action_vec_t r_pressed;
  action_vec_t r_released;
  logic [1:0]  r_dir;
  logic [5:0]  r_hold;
  jump_state_t r_state;
  logic [3:0]  r_buf_cnt;
  logic        r_jump_req;

  frame_tick_gen u_tick (
    .i_clk   (CLK),
    .i_rst_n (Reset_n),
    .i_vs    (frame_vs),
    .o_tick  (w_tick)
  );

  function automatic logic kc_hit(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] code);
    // A zero keycode means an empty slot and must never match.
    return (code != 8'h00) && ((a == code) || (b == code));
  endfunction

  always_comb begin
    w_dec          = '0;
    w_dec[A_LEFT]  = kc_hit(keycode0, keycode1, KC_LEFT);
    w_dec[A_RIGHT] = kc_hit(keycode0, keycode1, KC_RIGHT);
    w_dec[A_JUMP]  = kc_hit(keycode0, keycode1, KC_JUMP) |
                     kc_hit(keycode0, keycode1, KC_JUMP_ALT);
    w_dec[A_DOWN]  = kc_hit(keycode0, keycode1, KC_DOWN);
  end

  always_comb begin
    w_dir       = resolve_dir(w_dec);
    w_hold_next = 6'd0;
    if (w_dir != DIR_NONE) begin
      if (w_dir != r_dir) w_hold_next = 6'd1;
      else if (r_hold >= HOLD_SAT) w_hold_next = HOLD_SAT;
      else w_hold_next = r_hold + 6'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_held     <= '0;
      r_pressed  <= '0;
      r_released <= '0;
      r_dir      <= DIR_NONE;
      r_hold     <= '0;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
      if (w_tick) begin
        r_held     <= w_dec;
        r_pressed  <= w_dec & ~r_held;
        r_released <= ~w_dec & r_held;
        r_dir      <= w_dir;
        r_hold     <= w_hold_next;
      end
    end
  end

  // Jump buffer: ack beats a coincident tick, and a held key never re-arms.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_buf_cnt  <= '0;
      r_jump_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick && w_dec[A_JUMP] && !r_held[A_JUMP]) begin
            r_state    <= PEND;
            r_buf_cnt  <= BUF_LOAD;
            r_jump_req <= 1'b1;
          end
        end
        PEND: begin
          if (jump_ack) begin
            r_state    <= WAIT_REL;
            r_buf_cnt  <= '0;
            r_jump_req <= 1'b0;
          end else if (w_tick) begin
            r_buf_cnt <= r_buf_cnt - 4'd1;
            if (r_buf_cnt <= 4'd1) begin
              r_state    <= WAIT_REL;
              r_buf_cnt  <= '0;
              r_jump_req <= 1'b0;
            end
          end
        end
        WAIT_REL: begin
          if (w_tick && !w_dec[A_JUMP]) r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_buf_cnt  <= '0;
          r_jump_req <= 1'b0;
        end
      endcase
    end
  end

  assign frame_tick     = w_tick;
  assign held           = r_held;
  assign pressed        = r_pressed;
  assign released       = r_released;
  assign dir            = r_dir;
  assign move_hold      = r_hold;
  assign jump_req       = r_jump_req;
  assign dbg_jump_state = r_state;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed plus randomized frame sequences for key_event_decoder, checked
// against a frame-level behavioural model.
module tb_key_event_decoder;

  logic       CLK;
  logic       Reset_n;
  logic       frame_vs;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic       jump_ack;
  logic       frame_tick;
  logic [3:0] held;
  logic [3:0] pressed;
  logic [3:0] released;
  logic [1:0] dir;
  logic [5:0] move_hold;
  logic       jump_req;
  logic [1:0] dbg_jump_state;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model state
  logic [3:0] m_held;
  logic [3:0] m_pressed;
  logic [3:0] m_released;
  logic [1:0] m_dir;
  int         m_run;
  bit         m_pend;
  bit         m_wait_rel;
  int         m_left;

  key_event_decoder dut (
    .CLK            (CLK),
    .Reset_n        (Reset_n),
    .frame_vs       (frame_vs),
    .keycode0       (keycode0),
    .keycode1       (keycode1),
    .jump_ack       (jump_ack),
    .frame_tick     (frame_tick),
    .held           (held),
    .pressed        (pressed),
    .released       (released),
    .dir            (dir),
    .move_hold      (move_hold),
    .jump_req       (jump_req),
    .dbg_jump_state (dbg_jump_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] decode(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] d;
    d[0] = (a == 8'h04) || (b == 8'h04);
    d[1] = (a == 8'h07) || (b == 8'h07);
    d[2] = (a == 8'h1A) || (b == 8'h1A) || (a == 8'h2C) || (b == 8'h2C);
    d[3] = (a == 8'h16) || (b == 8'h16);
    return d;
  endfunction

  task automatic model_reset();
    m_held = '0; m_pressed = '0; m_released = '0; m_dir = 2'b00;
    m_run = 0; m_pend = 0; m_wait_rel = 0; m_left = 0;
  endtask

  task automatic model_tick(input logic [7:0] k0, input logic [7:0] k1, input bit ack);
    logic [3:0] d;
    logic [1:0] nd;
    d = decode(k0, k1);
    m_pressed  = d & ~m_held;
    m_released = ~d & m_held;
    if (m_pend && ack) begin
      m_pend = 0; m_wait_rel = 1;
    end else if (m_pend) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_pend = 0; m_wait_rel = 1; end
    end else if (m_wait_rel) begin
      if (!d[2]) m_wait_rel = 0;
    end else if (d[2] && !m_held[2]) begin
      m_pend = 1; m_left = 6;
    end
    if (d[0] && !d[1]) nd = 2'b11;
    else if (d[1] && !d[0]) nd = 2'b01;
    else nd = 2'b00;
    if (nd == 2'b00) m_run = 0;
    else if (nd == m_dir) m_run = m_run + 1;
    else m_run = 1;
    m_dir  = nd;
    m_held = d;
  endtask

  task automatic apply_reset(input logic [7:0] k0);
    Reset_n = 1'b0; jump_ack = 1'b0; frame_vs = 1'b1; keycode0 = k0; keycode1 = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_tick", frame_tick, 0);
    chk("rst_held", held, 0);
    chk("rst_pressed", pressed, 0);
    chk("rst_released", released, 0);
    chk("rst_dir", dir, 0);
    chk("rst_hold", move_hold, 0);
    chk("rst_jump_req", jump_req, 0);
    Reset_n = 1'b1;
    model_reset();
    @(negedge CLK);
  endtask

  // ack_mode: 0 none, 1 ack in the tick cycle, 2 ack one cycle after the outputs update
  task automatic do_frame(input logic [7:0] k0, input logic [7:0] k1, input int ack_mode);
    int lat;
    bit seen;
    keycode0 = 8'($urandom);
    keycode1 = 8'($urandom);
    frame_vs = 1'b0;
    repeat (3) @(negedge CLK);
    keycode0 = k0; keycode1 = k1;
    frame_vs = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 8) begin
      @(negedge CLK);
      lat++;
      if (frame_tick) seen = 1;
      else begin
        chk("held_stable", held, m_held);
        chk("pressed_idle", pressed, 0);
        chk("released_idle", released, 0);
      end
    end
    chk("tick_latency", seen ? lat : 0, 3);
    if (ack_mode == 1) jump_ack = 1'b1;
    model_tick(k0, k1, ack_mode == 1);
    @(negedge CLK);
    jump_ack = 1'b0;
    chk("tick_width", frame_tick, 0);
    chk("held", held, m_held);
    chk("pressed", pressed, m_pressed);
    chk("released", released, m_released);
    chk("dir", dir, m_dir);
    chk("move_hold", move_hold, (m_run > 63) ? 63 : m_run);
    chk("jump_req", jump_req, m_pend);
    @(negedge CLK);
    chk("pressed_clear", pressed, 0);
    chk("released_clear", released, 0);
    if (ack_mode == 2) begin
      jump_ack = 1'b1;
      @(negedge CLK);
      jump_ack = 1'b0;
      if (m_pend) begin m_pend = 0; m_wait_rel = 1; end
      chk("jump_req_ack", jump_req, m_pend);
    end
  endtask

  function automatic logic [7:0] pick_kc();
    logic [7:0] pool [8];
    pool = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h2C, 8'h16, 8'h00, 8'h00};
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    Reset_n = 1'b0; frame_vs = 1'b1; keycode0 = 8'h00; keycode1 = 8'h00; jump_ack = 1'b0;
    model_reset();

    // Reset with left held, then first frame reports it as a fresh press
    apply_reset(8'h04);
    do_frame(8'h04, 8'h00, 0);

    // Long right hold saturates, then adding left cancels
    for (int i = 0; i < 70; i++) do_frame(8'h07, 8'h00, 0);
    do_frame(8'h07, 8'h04, 0);
    do_frame(8'h00, 8'h00, 0);

    // Down held three frames then released
    for (int i = 0; i < 3; i++) do_frame(8'h16, 8'h00, 0);
    do_frame(8'h00, 8'h00, 0);
    do_frame(8'h16, 8'h16, 0);
    do_frame(8'h00, 8'h00, 0);

    // Space press, ack two frames later, holding does not re-arm
    do_frame(8'h00, 8'h2C, 0);
    do_frame(8'h00, 8'h2C, 0);
    do_frame(8'h00, 8'h2C, 2);
    for (int i = 0; i < 10; i++) do_frame(8'h00, 8'h2C, (i % 3 == 0) ? 2 : 0);
    do_frame(8'h00, 8'h00, 0);

    // W press never acked expires after six ticks, then re-press works
    for (int i = 0; i < 8; i++) do_frame(8'h1A, 8'h00, 0);
    do_frame(8'h00, 8'h00, 0);
    do_frame(8'h1A, 8'h00, 0);
    do_frame(8'h1A, 8'h00, 0);

    // Ack coinciding with a tick while pending
    do_frame(8'h00, 8'h00, 0);
    do_frame(8'h2C, 8'h1A, 0);
    do_frame(8'h2C, 8'h1A, 1);
    do_frame(8'h2C, 8'h00, 0);
    do_frame(8'h00, 8'h00, 1);

    // Reset while pending, key still down re-presses after reset
    do_frame(8'h1A, 8'h00, 0);
    apply_reset(8'h1A);
    do_frame(8'h1A, 8'h07, 0);
    do_frame(8'h1A, 8'h07, 2);

    // Randomized frames with sporadic acks
    for (int i = 0; i < 150; i++)
      do_frame(pick_kc(), pick_kc(), $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 2)) : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
